// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and constants for the write master and the later read master.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } wr_state_t;

  localparam logic [3:0] AWCACHE_DEFAULT = 4'b0011;

endpackage

// File: rtl/axil_cmd_fifo.sv
// Synchronous command FIFO: registered write, combinational head read.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module axil_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign empty = (r_wr_ptr == r_rd_ptr);

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign dout = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/axil_write_master.sv
// AXI4-Lite write master: queued commands are issued one at a time on AW/W/B
// and each completion is reported as a resp_valid pulse with its BRESP.
//
// state | meaning
// IDLE  | waiting for a queued command
// ISSUE | AW and W offered, each completing independently
// RESP  | bready high, waiting for the B handshake; pop on completion
module axil_write_master
  import axil_pkg::*;
#(
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32,
  parameter int         DEPTH  = 4,
  parameter logic [2:0] PROT   = 3'b000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                resp_valid,
  output logic [1:0]          resp_code,
  output logic                err,
  output logic                busy,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awprot,
  output logic [3:0]          awcache,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int SW = DATA_W / 8;
  localparam int FW = ADDR_W + DATA_W + SW;

  wr_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_awaddr, w_awaddr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [SW-1:0]     r_wstrb, w_wstrb_nxt;
  logic              r_awvalid, w_awvalid_nxt;
  logic              r_wvalid, w_wvalid_nxt;
  logic              r_bready, w_bready_nxt;
  logic              r_aw_done, w_aw_done_nxt;
  logic              r_w_done, w_w_done_nxt;
  logic              r_resp_valid, w_resp_valid_nxt;
  logic [1:0]        r_resp_code, w_resp_code_nxt;
  logic              r_err, w_err_nxt;

  logic [FW-1:0]     w_fifo_din, w_fifo_dout;
  logic              w_full, w_empty, w_pop;
  logic              w_aw_hs, w_w_hs, w_b_hs;

  assign cmd_ready  = !w_full;
  assign w_fifo_din = {cmd_addr, cmd_data, cmd_strb};

  axil_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .pop   (w_pop),
    .din   (w_fifo_din),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_aw_hs = r_awvalid && awready;
  assign w_w_hs  = r_wvalid && wready;
  assign w_b_hs  = r_bready && bvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_code  <= OKAY;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_awaddr     <= w_awaddr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_wstrb      <= w_wstrb_nxt;
      r_awvalid    <= w_awvalid_nxt;
      r_wvalid     <= w_wvalid_nxt;
      r_bready     <= w_bready_nxt;
      r_aw_done    <= w_aw_done_nxt;
      r_w_done     <= w_w_done_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_code  <= w_resp_code_nxt;
      r_err        <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_awaddr_nxt     = r_awaddr;
    w_wdata_nxt      = r_wdata;
    w_wstrb_nxt      = r_wstrb;
    w_awvalid_nxt    = r_awvalid;
    w_wvalid_nxt     = r_wvalid;
    w_bready_nxt     = r_bready;
    w_aw_done_nxt    = r_aw_done;
    w_w_done_nxt     = r_w_done;
    w_resp_valid_nxt = 1'b0;
    w_resp_code_nxt  = r_resp_code;
    w_err_nxt        = r_err;
    w_pop            = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt   = ISSUE;
          w_awaddr_nxt  = w_fifo_dout[FW-1 -: ADDR_W];
          w_wdata_nxt   = w_fifo_dout[SW +: DATA_W];
          w_wstrb_nxt   = w_fifo_dout[SW-1:0];
          w_awvalid_nxt = 1'b1;
          w_wvalid_nxt  = 1'b1;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      ISSUE: begin
        if (w_aw_hs) begin
          w_awvalid_nxt = 1'b0;
          w_aw_done_nxt = 1'b1;
        end
        if (w_w_hs) begin
          w_wvalid_nxt = 1'b0;
          w_w_done_nxt = 1'b1;
        end
        // A handshake landing this cycle counts toward completion.
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_state_nxt  = RESP;
          w_bready_nxt = 1'b1;
        end
      end
      RESP: begin
        if (w_b_hs) begin
          w_bready_nxt     = 1'b0;
          w_resp_valid_nxt = 1'b1;
          w_resp_code_nxt  = bresp;
          w_err_nxt        = r_err || (bresp != OKAY);
          w_pop            = 1'b1;
          w_state_nxt      = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign awaddr     = r_awaddr;
  assign awprot     = PROT;
  assign awcache    = r_awvalid ? AWCACHE_DEFAULT : 4'b0000;
  assign awvalid    = r_awvalid;
  assign wdata      = r_wdata;
  assign wstrb      = r_wstrb;
  assign wvalid     = r_wvalid;
  assign bready     = r_bready;
  assign resp_valid = r_resp_valid;
  assign resp_code  = r_resp_code;
  assign err        = r_err;
  assign busy       = !w_empty || (r_state != IDLE);

endmodule

// File: doc/axil_write_master.md
# axil_write_master

Parametrised AXI4-Lite write master that replaces the single-channel address driver. It accepts write commands (address, data, strobe) through a ready/valid port and buffers them in a small command FIFO. Each command is issued as one complete AXI4-Lite write transaction on the AW, W and B channels, and its response is reported back to the requester. It sits between the register-access logic and the AXI4-Lite interconnect, with one transaction outstanding at a time.

## Interface

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width; must be 32 or 64. WSTRB width is DATA_W/8.
- DEPTH, 4: command FIFO depth; must be a power of two, ≥2.
- PROT, 3'b000: value driven on awprot.

Ports (reset: reset, synchronous, active-high; clock: clk):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_addr  in  ADDR_W  write address.
- cmd_data  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  byte strobes.
- resp_valid  out  1  one-cycle pulse when a transaction completes.
- resp_code  out  2  BRESP of the completed transaction; holds its value between pulses.
- err  out  1  sticky; set by any non-OKAY response.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- awaddr  out  ADDR_W; awprot  out  3; awcache  out  4; awvalid  out  1; awready  in  1.
- wdata  out  DATA_W; wstrb  out  DATA_W/8; wvalid  out  1; wready  in  1.
- bresp  in  2; bvalid  in  1; bready  out  1.

## Operation

- **Command push.** A push occurs when cmd_valid && cmd_ready. cmd_ready = !full, and is combinational from the FIFO count. The FIFO pop happens only at the end of RESP.
- **FSM states:** IDLE, ISSUE, RESP.
- **IDLE → ISSUE** when the FIFO is non-empty.
  - Latch the head entry into awaddr, wdata and wstrb.
  - Assert awvalid=1 and wvalid=1 (registered).
  - Clear the internal flags aw_done and w_done.
- **ISSUE.** AW and W complete independently, in either order or in the same cycle.
  - On awvalid && awready: awvalid←0, aw_done←1.
  - On wvalid && wready: wvalid←0, w_done←1.
  - A valid stays asserted, with stable payload, until its handshake completes. It is never withdrawn.
  - **ISSUE → RESP** once both done flags are set, counting a handshake that completes in the current cycle. bready←1 on entry to RESP.
- **RESP.** On bvalid && bready:
  - bready←0, resp_valid←1 for one cycle, resp_code←bresp.
  - err←err | (bresp != OKAY).
  - Pop the FIFO; → IDLE.
- **bvalid outside RESP** is ignored (bready=0).
- **awready or wready while the matching valid is low** is ignored.
- **Fixed signals.**
  - awcache = 4'b0011 while awvalid is high, otherwise 4'b0000.
  - awprot = PROT at all times.
- **Reset values:** awaddr=0, wdata=0, wstrb=0, awvalid=0, wvalid=0, bready=0, resp_valid=0, resp_code=OKAY, err=0, FIFO empty, state=IDLE.
- **Reset mid-transaction** drops all valids and bready in the next cycle and discards every queued command. No response is reported for the aborted transaction.
- **FIFO pointers** are log2(DEPTH)+1 bits wide and wrap naturally.
  - full = addresses equal and MSBs differ.
  - empty = pointers equal.
- **Push while a pop occurs.**
  - If the FIFO is not full, push and pop in the same cycle are both honoured.
  - If the FIFO is full, cmd_ready stays low that cycle. There is no bypass.

## Timing

- Push at cycle N → head visible at N+1. IDLE transitions at N+1, and awvalid/wvalid are high at N+2.
- Minimum transaction time, with awready=wready=1 and bvalid returned the cycle after bready:
  - AW/W handshake at N+2.
  - bready high at N+3.
  - B handshake at N+4; resp_valid high at N+5.
  - IDLE at N+5.
- Back-to-back queued commands: the next awvalid rises 2 cycles after the previous B handshake.
- busy falls in the cycle after the final pop, provided no push has occurred.

## Structure

- **Package axil_pkg** holds:
  - the resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the wr_state_t enum {IDLE, ISSUE, RESP};
  - the constant AWCACHE_DEFAULT=4'b0011.
- **Sub-module axil_cmd_fifo** (WIDTH, DEPTH) is a synchronous FIFO with a registered-write, combinational-read head. Ports: push, pop, din, dout, full, empty. It is reused later by the read master.
- **Top level** contains the FSM, the output registers and the response/err logic.

## Test plan

- **Single write.** Push addr=0x0000_1000, data=0xDEAD_BEEF, strb=4'hF with ready tied high and bresp=OKAY. Require awvalid/wvalid at N+2 with awcache=4'b0011, resp_valid at N+5 with resp_code=OKAY, and err=0.
- **Skewed ready.** awready is delayed 3 cycles; wready is high immediately. Require wvalid to drop after 1 cycle while awvalid and awaddr hold steady until awready, and bready to rise only after both handshakes complete.
- **FIFO full.** Push 4 commands while awready=0 (DEPTH=4). Require cmd_ready=0 after the 4th push. Release awready and require four transactions in push order with the correct addr/data and cmd_ready returning to 1.
- **Error response.** Return bresp=SLVERR on the 2nd of 3 writes. Require resp_code=2'b10 on the 2nd pulse, err=1 from then onward, and err to remain 1 after an OKAY 3rd response.
- **Reset mid-transaction.** Assert reset while in ISSUE with awvalid=1 and 2 commands queued. Require the next cycle to show awvalid=wvalid=bready=0, busy=0, cmd_ready=1, and no resp_valid pulse.
- **Stray bvalid.** Pulse bvalid while IDLE. Require bready=0, no resp_valid and no change to err.
